eth_gmii_rx_framer: RTL and testbench

//  GMII receive framer, parametrised successor of the eth_mac_l2 RX path. Sits between one GMII PHY RX port
//  and the Avalon-ST source feeding the firewall core. Checks preamble/SFD, strips them, and buffers frame

---
 rtl/eth_gmii_rx_framer.sv | 276 +++++++++++++++++++++++++++
 tb/tb_eth_gmii_rx_framer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_gmii_rx_framer.sv
// ---------------------------------------------------------------------------
// eth_gmii_rx_framer
//   GMII receive framer. Registers the PHY RX signals, checks the
//   preamble/SFD, strips them, and buffers frame bytes (DA..FCS) in a
//   DEPTH-entry show-ahead FIFO. The FIFO feeds an Avalon-ST source with
//   SOP/EOP, a constant channel tag and per-frame error flags on the EOP beat:
//     error[0] RX_ER seen during the frame
//     error[1] length error (short frame, or truncated at MAX_LEN)
//     error[2] FIFO overflow, frame truncated
//     error[3] FCS mismatch (only when ETH_RX_FCS_CHECK_EN is defined)
//
// Configuration macro:
//   ETH_RX_FCS_CHECK_EN  - enables the CRC-32 residue check (error[3]);
//                          undefined: no CRC logic, error[3] tied 0.
//
// Ports:
//   Clk, Rst_n                 125 MHz GMII RX clock, async active-low reset
//   ENET_RX_DATA/DV/ER         GMII receive inputs
//   M_avalonST_*               Avalon-ST source (readyLatency 0)
//   frame_drop                 1-cycle pulse per frame discarded with no output
// ---------------------------------------------------------------------------
module eth_gmii_rx_framer #(
  parameter int CHANNEL_W  = 1,
  parameter int CHANNEL_ID = 0,
  parameter int DEPTH      = 64,
  parameter int MIN_PRE    = 2,
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 1518
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [7:0]           ENET_RX_DATA,
  input  logic                 ENET_RX_DV,
  input  logic                 ENET_RX_ER,
  output logic                 M_avalonST_valid,
  output logic [7:0]           M_avalonST_data,
  output logic [CHANNEL_W-1:0] M_avalonST_channel,
  output logic [3:0]           M_avalonST_error,
  output logic                 M_avalonST_startofpacket,
  output logic                 M_avalonST_endofpacket,
  input  logic                 M_avalonST_ready,
  output logic                 frame_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LIM_FIRST = (AW+1)'(DEPTH-1);
  localparam logic [AW:0] LIM_OVF   = (AW+1)'(DEPTH-2);
  localparam logic [15:0] MIN_LEN_C = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN_C = 16'(MAX_LEN);
  localparam logic [2:0]  MIN_PRE_C = 3'(MIN_PRE);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DISC} state_t;

  state_t state;
  logic [2:0] pre_cnt;

  // ---- stage p0: GMII input register ----
  logic [7:0] rxd_p0;
  logic       dv_p0;
  logic       er_p0;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      dv_p0 <= 1'b0;
      er_p0 <= 1'b0;
    end else begin
      dv_p0 <= ENET_RX_DV;
      er_p0 <= ENET_RX_ER;
    end
  end

  always_ff @(posedge Clk) begin
    rxd_p0 <= ENET_RX_DATA;
  end

  // ---- stage p1: one-byte hold register ----
  // The byte is held one cycle so that the end of DV can still mark it EOP.
  logic [7:0]  hold_data_p1;
  logic        vld_p1;
  logic        sop_p1;
  logic [15:0] len_p1;
  logic        er_st_p1;
  logic        fcs_bad;

  // FIFO bookkeeping
  logic [13:0]   mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, rd_nxt, used, eff;
  logic          pop;
  logic          vld_p2;

  assign pop    = vld_p2 & M_avalonST_ready;
  assign rd_nxt = rd_ptr + {{AW{1'b0}}, pop};
  assign used   = wr_ptr - rd_ptr;
  // Occupancy as seen by a write this cycle; a same-cycle pop frees a slot.
  assign eff    = used - {{AW{1'b0}}, pop};

  // DATA-state decode. The held byte counts against the FIFO: a normal write
  // is only allowed while it leaves room for one more (EOP) entry, so a
  // started frame can always be closed. A frame whose very first write finds
  // no room at all is dropped instead of started.
  logic        wr_en;
  logic [13:0] wr_entry;
  logic        acc;
  logic        dat_drop, dat_idle, dat_disc;

  always_comb begin
    wr_en    = 1'b0;
    wr_entry = '0;
    acc      = 1'b0;
    dat_drop = 1'b0;
    dat_idle = 1'b0;
    dat_disc = 1'b0;
    if (state == S_DATA) begin
      if (!vld_p1) begin
        if (dv_p0) begin
          acc = 1'b1;
        end else begin
          dat_drop = 1'b1;
          dat_idle = 1'b1;
        end
      end else if (sop_p1 && (eff >= LIM_FIRST)) begin
        dat_drop = 1'b1;
        if (dv_p0) dat_disc = 1'b1;
        else       dat_idle = 1'b1;
      end else if (!dv_p0) begin
        wr_en    = 1'b1;
        wr_entry = {hold_data_p1, sop_p1, 1'b1,
                    fcs_bad, 1'b0, (len_p1 < MIN_LEN_C), er_st_p1};
        dat_idle = 1'b1;
      end else if (len_p1 == MAX_LEN_C) begin
        wr_en    = 1'b1;
        wr_entry = {hold_data_p1, sop_p1, 1'b1, 1'b0, 1'b0, 1'b1, er_st_p1};
        dat_disc = 1'b1;
      end else if (eff >= LIM_OVF) begin
        wr_en    = 1'b1;
        wr_entry = {hold_data_p1, sop_p1, 1'b1, 1'b0, 1'b1, 1'b0, er_st_p1};
        dat_disc = 1'b1;
      end else begin
        wr_en    = 1'b1;
        wr_entry = {hold_data_p1, sop_p1, 1'b0, 4'b0000};
        acc      = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= S_IDLE;
      pre_cnt    <= 3'd0;
      frame_drop <= 1'b0;
      vld_p1     <= 1'b0;
      sop_p1     <= 1'b0;
      len_p1     <= 16'd0;
      er_st_p1   <= 1'b0;
    end else begin
      frame_drop <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dv_p0) begin
            if (rxd_p0 == 8'h55) begin
              state   <= S_PRE;
              pre_cnt <= 3'd1;
            end else begin
              state      <= S_DISC;
              frame_drop <= 1'b1;
            end
          end
        end
        S_PRE: begin
          if (!dv_p0) begin
            state      <= S_IDLE;
            frame_drop <= 1'b1;
          end else if (rxd_p0 == 8'h55) begin
            if (pre_cnt != 3'd7) pre_cnt <= pre_cnt + 3'd1;
          end else if ((rxd_p0 == 8'hD5) && (pre_cnt >= MIN_PRE_C)) begin
            state    <= S_DATA;
            vld_p1   <= 1'b0;
            len_p1   <= 16'd0;
            er_st_p1 <= 1'b0;
          end else begin
            state      <= S_DISC;
            frame_drop <= 1'b1;
          end
        end
        S_DATA: begin
          frame_drop <= dat_drop;
          if (dat_idle)      state <= S_IDLE;
          else if (dat_disc) state <= S_DISC;
          if (acc) begin
            vld_p1   <= 1'b1;
            sop_p1   <= !vld_p1;
            len_p1   <= len_p1 + 16'd1;
            er_st_p1 <= er_st_p1 | er_p0;
          end
          if (dat_idle || dat_disc) vld_p1 <= 1'b0;
        end
        default: begin
          if (!dv_p0) state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (acc) hold_data_p1 <= rxd_p0;
  end

`ifdef ETH_RX_FCS_CHECK_EN
  // Reflected CRC-32 (poly 0x04C11DB7), one byte per call.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  logic [31:0] crc_p1;

  // Seeded throughout the preamble, so every frame starts from all-ones.
  always_ff @(posedge Clk) begin
    if (state == S_PRE) crc_p1 <= 32'hFFFFFFFF;
    else if (acc)       crc_p1 <= crc_byte(crc_p1, rxd_p0);
  end

  // The register runs LSB-first; reverse it to compare with the residue.
  assign fcs_bad = (rev32(crc_p1) != 32'hC704DD7B);
`else
  assign fcs_bad = 1'b0;
`endif

  // ---- stage p2: FIFO storage and show-ahead output register ----
  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  logic [7:0] data_p2;
  logic       sop_p2, eop_p2;
  logic [3:0] err_p2;

  // The output register reloads from the head every cycle; the write
  // pointer is the pre-write value, so a fresh entry shows one edge later.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      vld_p2  <= 1'b0;
      data_p2 <= 8'h00;
      sop_p2  <= 1'b0;
      eop_p2  <= 1'b0;
      err_p2  <= 4'h0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      rd_ptr <= rd_nxt;
      vld_p2 <= (wr_ptr != rd_nxt);
      if (wr_ptr != rd_nxt) begin
        {data_p2, sop_p2, eop_p2, err_p2} <= mem[rd_nxt[AW-1:0]];
      end
    end
  end

  assign M_avalonST_valid         = vld_p2;
  assign M_avalonST_data          = data_p2;
  assign M_avalonST_startofpacket = sop_p2;
  assign M_avalonST_endofpacket   = eop_p2;
  assign M_avalonST_error         = err_p2;
  assign M_avalonST_channel       = CHANNEL_W'(CHANNEL_ID);

endmodule

// File: tb/tb_eth_gmii_rx_framer.sv
// ---------------------------------------------------------------------------
// tb_eth_gmii_rx_framer
//   Scoreboard bench for eth_gmii_rx_framer: every frame pushes its expected
//   beats when driven; a monitor pops and compares on each accepted beat.
// ---------------------------------------------------------------------------
module tb_eth_gmii_rx_framer;

  localparam int CH_W  = 1;
  localparam int CH_ID = 1;

`ifdef ETH_RX_FCS_CHECK_EN
  localparam logic [3:0] FCS_ERR = 4'b1000;
`else
  localparam logic [3:0] FCS_ERR = 4'b0000;
`endif

  logic            clk;
  logic            Rst_n;
  logic [7:0]      rx_data;
  logic            rx_dv;
  logic            rx_er;
  logic            m_valid;
  logic [7:0]      m_data;
  logic [CH_W-1:0] m_channel;
  logic [3:0]      m_error;
  logic            m_sop;
  logic            m_eop;
  logic            m_ready;
  logic            frame_drop;

  eth_gmii_rx_framer #(
    .CHANNEL_W (CH_W),
    .CHANNEL_ID(CH_ID),
    .DEPTH     (64),
    .MIN_PRE   (2),
    .MIN_LEN   (64),
    .MAX_LEN   (1518)
  ) dut (
    .Clk                     (clk),
    .Rst_n                   (Rst_n),
    .ENET_RX_DATA            (rx_data),
    .ENET_RX_DV              (rx_dv),
    .ENET_RX_ER              (rx_er),
    .M_avalonST_valid        (m_valid),
    .M_avalonST_data         (m_data),
    .M_avalonST_channel      (m_channel),
    .M_avalonST_error        (m_error),
    .M_avalonST_startofpacket(m_sop),
    .M_avalonST_endofpacket  (m_eop),
    .M_avalonST_ready        (m_ready),
    .frame_drop              (frame_drop)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic [3:0] err;
    logic [3:0] mask;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_err = 0;
  int         drop_cnt = 0;
  int         beat_cnt = 0;
  logic [7:0] fbuf [0:2047];
  int         flen;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (Rst_n) begin
      if (frame_drop) drop_cnt++;
      if (m_valid && m_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          check_val("unexpected_beat", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_val("data", {24'h0, m_data}, {24'h0, mon_e.d});
          check_val("sop", {31'h0, m_sop}, {31'h0, mon_e.sop});
          check_val("eop", {31'h0, m_eop}, {31'h0, mon_e.eop});
          check_val("error", {28'h0, m_error & mon_e.mask}, {28'h0, mon_e.err & mon_e.mask});
          check_val("channel", 32'(m_channel), 32'(CH_ID));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Standard Ethernet CRC-32 generator; FCS is appended LSB byte first.
  task automatic build_frame(input int npay, input logic [7:0] seed);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < npay; i++) begin
      fbuf[i] = 8'(i) + seed;
      c = c ^ {24'h0, fbuf[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    fbuf[npay]   = c[7:0];
    fbuf[npay+1] = c[15:8];
    fbuf[npay+2] = c[23:16];
    fbuf[npay+3] = c[31:24];
    flen = npay + 4;
  endtask

  task automatic push_frame(input int n, input logic [3:0] err, input logic [3:0] mask);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d    = fbuf[i];
      e.sop  = (i == 0);
      e.eop  = (i == n - 1);
      e.err  = (i == n - 1) ? err : 4'h0;
      e.mask = (i == n - 1) ? mask : 4'hF;
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_frame(input int npre, input int er_idx);
    for (int i = 0; i < npre; i++) begin
      rx_dv = 1'b1; rx_data = 8'h55; rx_er = 1'b0;
      tick();
    end
    rx_data = 8'hD5;
    tick();
    for (int i = 0; i < flen; i++) begin
      rx_data = fbuf[i];
      rx_er   = (i == er_idx);
      tick();
    end
    rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
    tick();
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) tick();
    check_val(tag, 32'(exp_q.size()), 32'd0);
    repeat (4) tick();
    check_val({tag, "_idle"}, {31'h0, m_valid}, 32'd0);
  endtask

  int d0, b0;

  initial begin
    Rst_n   = 1'b0;
    rx_data = 8'h00;
    rx_dv   = 1'b0;
    rx_er   = 1'b0;
    m_ready = 1'b0;
    #22;
    check_val("rst_valid", {31'h0, m_valid}, 32'd0);
    check_val("rst_data", {24'h0, m_data}, 32'd0);
    check_val("rst_sop", {31'h0, m_sop}, 32'd0);
    check_val("rst_eop", {31'h0, m_eop}, 32'd0);
    check_val("rst_error", {28'h0, m_error}, 32'd0);
    check_val("rst_drop", {31'h0, frame_drop}, 32'd0);
    check_val("rst_channel", 32'(m_channel), 32'(CH_ID));
    tick();
    Rst_n = 1'b1;
    tick();
    m_ready = 1'b1;

    // Good 64-byte frame, sent twice back-to-back with a 1-cycle gap.
    build_frame(60, 8'h00);
    push_frame(flen, 4'b0000, 4'hF);
    push_frame(flen, 4'b0000, 4'hF);
    drive_frame(7, -1);
    drive_frame(7, -1);
    wait_drain("t1_good");

    // RX_ER on byte 10.
    push_frame(flen, 4'b0001, 4'hF);
    drive_frame(7, 10);
    wait_drain("t2_rxer");

    // 40-byte frame is short.
    build_frame(36, 8'h20);
    push_frame(flen, 4'b0010, 4'hF);
    drive_frame(7, -1);
    wait_drain("t2_short");

    // Corrupted FCS byte, minimum preamble.
    build_frame(60, 8'h00);
    fbuf[flen-2] = fbuf[flen-2] ^ 8'hFF;
    push_frame(flen, FCS_ERR, 4'hF);
    drive_frame(2, -1);
    wait_drain("t3_fcs");

    // Overflow: 200-byte frame into a stalled sink keeps 63 entries.
    m_ready = 1'b0;
    build_frame(196, 8'h00);
    push_frame(63, 4'b0100, 4'b0100);
    drive_frame(7, -1);
    repeat (5) tick();
    check_val("t4_valid_stalled", {31'h0, m_valid}, 32'd1);
    check_val("t4_head_sop", {31'h0, m_sop}, 32'd1);
    m_ready = 1'b1;
    wait_drain("t4_ovf");

    // Frame longer than MAX_LEN is truncated at 1518 bytes.
    build_frame(1516, 8'h11);
    push_frame(1518, 4'b0010, 4'hF);
    drive_frame(7, -1);
    wait_drain("t_maxlen");

    // Bad first byte, then a too-short preamble.
    d0 = drop_cnt; b0 = beat_cnt;
    rx_dv = 1'b1; rx_data = 8'hAA; tick();
    rx_dv = 1'b0; rx_data = 8'h00; tick();
    rx_dv = 1'b1; rx_data = 8'h55; tick();
    rx_data = 8'hD5; tick();
    rx_dv = 1'b0; rx_data = 8'h00; tick();
    repeat (5) tick();
    check_val("t5_drops", 32'(drop_cnt - d0), 32'd2);
    check_val("t5_no_beats", 32'(beat_cnt - b0), 32'd0);

    // SFD followed immediately by end of DV.
    d0 = drop_cnt;
    flen = 0;
    drive_frame(7, -1);
    repeat (4) tick();
    check_val("t5_zero_len_drop", 32'(drop_cnt - d0), 32'd1);
    check_val("t5_zero_len_beats", 32'(beat_cnt - b0), 32'd0);

    // Reset in the middle of a frame.
    m_ready = 1'b0;
    build_frame(60, 8'h00);
    for (int i = 0; i < 7; i++) begin
      rx_dv = 1'b1; rx_data = 8'h55; tick();
    end
    rx_data = 8'hD5; tick();
    for (int i = 0; i < 30; i++) begin
      rx_data = fbuf[i]; tick();
    end
    check_val("t6_valid_before", {31'h0, m_valid}, 32'd1);
    Rst_n = 1'b0;
    #1;
    check_val("t6_valid", {31'h0, m_valid}, 32'd0);
    check_val("t6_data", {24'h0, m_data}, 32'd0);
    check_val("t6_sop", {31'h0, m_sop}, 32'd0);
    check_val("t6_eop", {31'h0, m_eop}, 32'd0);
    check_val("t6_error", {28'h0, m_error}, 32'd0);
    rx_dv = 1'b0; rx_data = 8'h00;
    repeat (3) tick();
    Rst_n = 1'b1;
    repeat (2) tick();
    m_ready = 1'b1;
    push_frame(flen, 4'b0000, 4'hF);
    drive_frame(7, -1);
    wait_drain("t6_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
